// File: rtl/vga_line_capture_if.sv
// Captured-line stream: a packed line word plus its line number under valid/ready.
// With VGA_LINE_CAPTURE_PIXCOUNT_EN defined the stream also carries the raw pixel count.
interface vga_line_capture_if #(
  parameter int H_ACTIVE = 848,
  parameter int Y_BITS   = 9
);
  logic [2*H_ACTIVE-1:0] line_data;
  logic [Y_BITS-1:0]     line_y;
  logic                  line_valid;
  logic                  line_ready;
`ifdef VGA_LINE_CAPTURE_PIXCOUNT_EN
  logic [11:0]           line_pix_cnt;
`endif

  modport master (
    input  line_ready,
    output line_data, line_y, line_valid
`ifdef VGA_LINE_CAPTURE_PIXCOUNT_EN
    , line_pix_cnt
`endif
  );

  modport slave (
    output line_ready,
    input  line_data, line_y, line_valid
`ifdef VGA_LINE_CAPTURE_PIXCOUNT_EN
    , line_pix_cnt
`endif
  );
endinterface

// File: rtl/vga_line_capture.sv
// Recovers lines from a VGA HS/VS/BLANK_N/RGB stream and packs them as 2-bit colour codes.
// Optional raw per-line pixel count output: define VGA_LINE_CAPTURE_PIXCOUNT_EN.
module vga_line_capture #(
  parameter int H_ACTIVE = 848,
  parameter int Y_BITS   = 9
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  input  logic       VGA_BLANK_N,
  input  logic [7:0] VGA_R,
  input  logic [7:0] VGA_G,
  input  logic [7:0] VGA_B,
  vga_line_capture_if.master stream,
  output logic       frame_start,
  output logic       short_err,
  output logic       long_err,
  output logic       drop_err
);
  localparam int W  = 2 * H_ACTIVE;
  localparam int IW = $clog2(H_ACTIVE + 1);

  typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, CAPTURE} state_t;

  state_t            state;
  logic              hs_s0, vs_s0, blank_s0, r_msb, g_msb, b_msb;
  logic              hs_s1, vs_s1, blank_s1;
  logic [1:0]        code;
  logic [W-1:0]      shadow;
  logic [IW-1:0]     idx;
  logic [Y_BITS-1:0] line_cnt;
`ifdef VGA_LINE_CAPTURE_PIXCOUNT_EN
  logic [11:0]       pix_cnt;
`endif

  // Only the colour MSBs take part in quantisation.
  logic unused_colour_bits;
  assign unused_colour_bits = ^{VGA_R[6:0], VGA_G[6:0], VGA_B[6:0]};

  logic vs_fall, blank_rise, blank_fall, hs_fall, line_end;
  assign vs_fall    = vs_s1 & ~vs_s0;
  assign blank_rise = ~blank_s1 & blank_s0;
  assign blank_fall = blank_s1 & ~blank_s0;
  assign hs_fall    = hs_s1 & ~hs_s0;
  assign line_end   = blank_fall | hs_fall;

  always_comb begin
    code = 2'd0;
    if (r_msb)      code = 2'd1;
    else if (g_msb) code = 2'd2;
    else if (b_msb) code = 2'd3;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {hs_s0, vs_s0, blank_s0, r_msb, g_msb, b_msb} <= '0;
      {hs_s1, vs_s1, blank_s1}                      <= '0;
    end else begin
      hs_s0    <= VGA_HS;
      vs_s0    <= VGA_VS;
      blank_s0 <= VGA_BLANK_N;
      r_msb    <= VGA_R[7];
      g_msb    <= VGA_G[7];
      b_msb    <= VGA_B[7];
      hs_s1    <= hs_s0;
      vs_s1    <= vs_s0;
      blank_s1 <= blank_s0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state             <= WAIT_FRAME;
      shadow            <= '0;
      idx               <= '0;
      line_cnt          <= '0;
      frame_start       <= 1'b0;
      short_err         <= 1'b0;
      long_err          <= 1'b0;
      drop_err          <= 1'b0;
      stream.line_data  <= '0;
      stream.line_y     <= '0;
      stream.line_valid <= 1'b0;
`ifdef VGA_LINE_CAPTURE_PIXCOUNT_EN
      pix_cnt             <= '0;
      stream.line_pix_cnt <= '0;
`endif
    end else begin
      frame_start <= vs_fall;
      if (vs_fall) line_cnt <= '0;
      // Acceptance retires the word; a load below in the same cycle overrides this.
      if (stream.line_valid && stream.line_ready) stream.line_valid <= 1'b0;

      case (state)
        WAIT_FRAME: begin
          if (vs_fall) state <= WAIT_LINE;
        end
        WAIT_LINE: begin
          if (blank_rise) begin
            shadow <= W'(code);
            idx    <= IW'(1);
`ifdef VGA_LINE_CAPTURE_PIXCOUNT_EN
            pix_cnt <= 12'd1;
`endif
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (vs_fall) begin
            state <= WAIT_LINE;
          end else if (line_end) begin
            state    <= WAIT_LINE;
            line_cnt <= line_cnt + 1'b1;
            if (idx != IW'(H_ACTIVE)) short_err <= 1'b1;
            if (!stream.line_valid || stream.line_ready) begin
              stream.line_data  <= shadow;
              stream.line_y     <= line_cnt;
              stream.line_valid <= 1'b1;
`ifdef VGA_LINE_CAPTURE_PIXCOUNT_EN
              stream.line_pix_cnt <= pix_cnt;
`endif
            end else begin
              drop_err <= 1'b1;
            end
          end else if (blank_s0) begin
`ifdef VGA_LINE_CAPTURE_PIXCOUNT_EN
            pix_cnt <= pix_cnt + 12'd1;
`endif
            // Index saturates at H_ACTIVE; overflow pixels only flag the error.
            if (idx == IW'(H_ACTIVE)) begin
              long_err <= 1'b1;
            end else begin
              shadow[{idx, 1'b0} +: 2] <= code;
              idx                      <= idx + 1'b1;
            end
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_line_capture.sv
// Directed bench for vga_line_capture with an 8-pixel line: table of single-line
// scenarios plus hand-written sequences for handshake, abort, HS end and reset.
module tb_vga_line_capture;
  localparam int H = 8;
  localparam int Y = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, blank = 1'b0;
  logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
  logic       frame_start, short_err, long_err, drop_err;

  vga_line_capture_if #(.H_ACTIVE(H), .Y_BITS(Y)) lif ();

  vga_line_capture #(.H_ACTIVE(H), .Y_BITS(Y)) dut (
    .CLK(clk), .RST_N(rst_n), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .stream(lif),
    .frame_start(frame_start), .short_err(short_err), .long_err(long_err),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int fs_count = 0;
  int acc_y[$];

  always @(negedge clk) begin
    #1;
    if (frame_start === 1'b1) fs_count++;
    if (lif.line_valid === 1'b1 && lif.line_ready === 1'b1) acc_y.push_back(int'(lif.line_y));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pix(input logic [1:0] c, input bit mix);
    if (!mix) begin
      r = (c == 2'd1) ? 8'hFF : 8'h00;
      g = (c == 2'd2) ? 8'hFF : 8'h00;
      b = (c == 2'd3) ? 8'hFF : 8'h00;
    end else begin
      case (c)
        2'd1:    begin r = 8'h80; g = 8'hFF; b = 8'hFF; end
        2'd2:    begin r = 8'h7F; g = 8'h80; b = 8'hFF; end
        2'd3:    begin r = 8'h7F; g = 8'h7F; b = 8'h80; end
        default: begin r = 8'h7F; g = 8'h7F; b = 8'h7F; end
      endcase
    end
  endtask

  task automatic put_pixels(input int n, input logic [31:0] codes, input bit mix);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      blank = 1'b1;
      set_pix(codes[2*i +: 2], mix);
    end
  endtask

  task automatic end_line();
    @(negedge clk); blank = 1'b0; set_pix(2'd0, 1'b0);
    @(negedge clk);
    @(negedge clk); hs = 1'b0;
    @(negedge clk); hs = 1'b1;
    @(negedge clk);
  endtask

  task automatic vs_pulse();
    @(negedge clk); vs = 1'b0;
    @(negedge clk);
    @(negedge clk); vs = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; lif.line_ready = 1'b0; blank = 1'b0; hs = 1'b1; vs = 1'b1;
    set_pix(2'd0, 1'b0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    int          npix;
    logic [31:0] codes;
    bit          mix;
    logic [15:0] exp_data;
    bit          exp_short;
    bit          exp_long;
    int          exp_cnt;
  } vec_t;

  vec_t vt[6];

  initial begin
    int fs0;
    lif.line_ready = 1'b0;
    vt[0] = '{"rgb0",       8,  32'h3939,  1'b0, 16'h3939, 1'b0, 1'b0, 8};
    vt[1] = '{"short_red",  5,  32'h0155,  1'b0, 16'h0155, 1'b1, 1'b0, 5};
    vt[2] = '{"long_green", 10, 32'hAAAAA, 1'b0, 16'hAAAA, 1'b0, 1'b1, 10};
    vt[3] = '{"prio_mix",   8,  32'h3939,  1'b1, 16'h3939, 1'b0, 1'b0, 8};
    vt[4] = '{"blue_mix",   8,  32'h90FF,  1'b0, 16'h90FF, 1'b0, 1'b0, 8};
    vt[5] = '{"black_mix",  8,  32'h0000,  1'b1, 16'h0000, 1'b0, 1'b0, 8};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      chk($sformatf("%s.rst_valid", vt[i].name), 32'(lif.line_valid), 32'd0);
      chk($sformatf("%s.rst_data", vt[i].name), 32'(lif.line_data), 32'd0);
      chk($sformatf("%s.rst_errs", vt[i].name), 32'({short_err, long_err, drop_err, frame_start}), 32'd0);
      fs0 = fs_count;
      vs_pulse();
      chk($sformatf("%s.frame_start", vt[i].name), 32'(fs_count - fs0), 32'd1);
      put_pixels(vt[i].npix, vt[i].codes, vt[i].mix);
      end_line();
      chk($sformatf("%s.valid", vt[i].name), 32'(lif.line_valid), 32'd1);
      chk($sformatf("%s.data", vt[i].name), 32'(lif.line_data), 32'(vt[i].exp_data));
      chk($sformatf("%s.y", vt[i].name), 32'(lif.line_y), 32'd0);
      chk($sformatf("%s.short", vt[i].name), 32'(short_err), 32'(vt[i].exp_short));
      chk($sformatf("%s.long", vt[i].name), 32'(long_err), 32'(vt[i].exp_long));
      chk($sformatf("%s.drop", vt[i].name), 32'(drop_err), 32'd0);
`ifdef VGA_LINE_CAPTURE_PIXCOUNT_EN
      chk($sformatf("%s.pix_cnt", vt[i].name), 32'(lif.line_pix_cnt), 32'(vt[i].exp_cnt));
`endif
      @(negedge clk); lif.line_ready = 1'b1;
      @(negedge clk); lif.line_ready = 1'b0;
      chk($sformatf("%s.accept", vt[i].name), 32'(lif.line_valid), 32'd0);
    end

    // Output latency: valid rises two edges after raw BLANK_N falls.
    do_reset();
    vs_pulse();
    put_pixels(8, 32'h3939, 1'b0);
    @(negedge clk); blank = 1'b0; set_pix(2'd0, 1'b0);
    @(negedge clk); chk("lat.edge1", 32'(lif.line_valid), 32'd0);
    @(negedge clk); chk("lat.edge2", 32'(lif.line_valid), 32'd1);
    chk("lat.data", 32'(lif.line_data), 32'h3939);

    // Backpressure: second line dropped, first held; counter still advances.
    do_reset();
    vs_pulse();
    put_pixels(8, 32'h3939, 1'b0); end_line();
    put_pixels(8, 32'hFFFF, 1'b0); end_line();
    chk("drop.valid", 32'(lif.line_valid), 32'd1);
    chk("drop.data", 32'(lif.line_data), 32'h3939);
    chk("drop.y", 32'(lif.line_y), 32'd0);
    chk("drop.err", 32'(drop_err), 32'd1);
    @(negedge clk); lif.line_ready = 1'b1;
    @(negedge clk); chk("drop.release", 32'(lif.line_valid), 32'd0);
    acc_y.delete();
    put_pixels(8, 32'h90FF, 1'b0); end_line();
    lif.line_ready = 1'b0;
    chk("drop.next_count", 32'(acc_y.size()), 32'd1);
    chk("drop.next_y", (acc_y.size() > 0) ? 32'(acc_y[0]) : 32'hFFFF_FFFF, 32'd2);

    // VS falling mid-line discards the partial line and restarts numbering.
    do_reset();
    vs_pulse();
    lif.line_ready = 1'b1;
    put_pixels(8, 32'h3939, 1'b0); end_line();
    lif.line_ready = 1'b0;
    put_pixels(3, 32'h15, 1'b0);
    @(negedge clk); vs = 1'b0;
    @(negedge clk); blank = 1'b0; set_pix(2'd0, 1'b0);
    @(negedge clk); vs = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort.valid", 32'(lif.line_valid), 32'd0);
    chk("abort.short", 32'(short_err), 32'd0);
    put_pixels(8, 32'h90FF, 1'b0); end_line();
    chk("abort.next_valid", 32'(lif.line_valid), 32'd1);
    chk("abort.next_y", 32'(lif.line_y), 32'd0);
    chk("abort.next_data", 32'(lif.line_data), 32'h90FF);

    // Continuous ready: three lines streamed without loss.
    do_reset();
    vs_pulse();
    lif.line_ready = 1'b1;
    acc_y.delete();
    for (int k = 0; k < 3; k++) begin
      put_pixels(8, 32'h3939, 1'b0); end_line();
    end
    lif.line_ready = 1'b0;
    chk("stream.count", 32'(acc_y.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("stream.y%0d", k), (acc_y.size() > k) ? 32'(acc_y[k]) : 32'hFFFF_FFFF, 32'(k));
    chk("stream.drop", 32'(drop_err), 32'd0);

    // HS low inside active video terminates the line.
    do_reset();
    vs_pulse();
    put_pixels(4, 32'h55, 1'b0);
    @(negedge clk); hs = 1'b0; set_pix(2'd1, 1'b0);
    @(negedge clk); hs = 1'b1;
    @(negedge clk); blank = 1'b0; set_pix(2'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hs_end.valid", 32'(lif.line_valid), 32'd1);
    chk("hs_end.data", 32'(lif.line_data), 32'h0055);
    chk("hs_end.short", 32'(short_err), 32'd1);
    chk("hs_end.y", 32'(lif.line_y), 32'd0);

    // Asynchronous reset mid-capture, then wait for a fresh frame.
    do_reset();
    vs_pulse();
    put_pixels(8, 32'h3939, 1'b0); end_line();
    chk("areset.pre_valid", 32'(lif.line_valid), 32'd1);
    put_pixels(4, 32'h55, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.valid", 32'(lif.line_valid), 32'd0);
    chk("areset.data", 32'(lif.line_data), 32'd0);
    chk("areset.y_errs", 32'({lif.line_y, short_err, long_err, drop_err, frame_start}), 32'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); blank = 1'b0; set_pix(2'd0, 1'b0);
    put_pixels(8, 32'h3939, 1'b0); end_line();
    chk("areset.no_frame", 32'(lif.line_valid), 32'd0);
    vs_pulse();
    put_pixels(8, 32'h90FF, 1'b0); end_line();
    chk("areset.after_valid", 32'(lif.line_valid), 32'd1);
    chk("areset.after_y", 32'(lif.line_y), 32'd0);
    chk("areset.after_data", 32'(lif.line_data), 32'h90FF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
